parking_slot_controller: RTL and testbench

Sequential controller that owns the 8-slot occupancy map of the smart parking system and sequences the entry and exit gates. It serves one request at a time. Entry requests receive the lowest-numbered free slot; exit requests release a named slot. Each granted request opens the matching gate for a fixed number of cycles. The controller sits between the gate sensors and the display/capacity logic, and its `free_mask` output is the system's authoritative capacity vector.

---
 rtl/parking_slot_controller.sv | 174 +++++++++++++++++
 tb/tb_parking_slot_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_controller.sv
// Smart-parking slot controller: owns the 8-slot occupancy map,
// grants entries to the lowest free slot and sequences both gates.
module parking_slot_controller #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  output logic       entry_ack,
  output logic [2:0] assigned_slot,
  output logic       entry_reject,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic [7:0] free_mask,
  output logic [3:0] free_count,
  output logic       full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY_GATE,
    S_EXIT_GATE,
    S_RELEASE
  } state_t;

  localparam logic [3:0] TIMER_LOAD = 4'(GATE_CYCLES - 1);

  state_t     r_state;
  logic       r_served_exit;
  logic [3:0] r_timer;
  logic [7:0] r_free_mask;
  logic [3:0] r_free_count;
  logic       r_full;
  logic [2:0] r_assigned_slot;
  logic       r_entry_ack;
  logic       r_entry_reject;
  logic       r_exit_ack;
  logic       r_exit_err;
  logic       r_entry_gate;
  logic       r_exit_gate;

  logic [2:0] w_low_idx;
  logic       w_has_free;
  logic       w_exit_occ;
  logic       w_served_req;
  logic [7:0] w_mask_set;
  logic [7:0] w_mask_clr;
  logic [3:0] w_cnt_set;
  logic [3:0] w_cnt_clr;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 8; k++) begin
      c = c + {3'd0, m[k]};
    end
    return c;
  endfunction

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_free_mask[i]) begin
        w_low_idx = 3'(i);
      end
    end
  end

  assign w_has_free   = |r_free_mask;
  assign w_exit_occ   = ~r_free_mask[exit_slot];
  assign w_mask_set   = r_free_mask | (8'b1 << exit_slot);
  assign w_mask_clr   = r_free_mask & ~(8'b1 << w_low_idx);
  assign w_cnt_set    = popcount8(w_mask_set);
  assign w_cnt_clr    = popcount8(w_mask_clr);
  assign w_served_req = r_served_exit ? exit_req : entry_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_served_exit   <= 1'b0;
      r_timer         <= 4'd0;
      r_free_mask     <= 8'hFF;
      r_free_count    <= 4'd8;
      r_full          <= 1'b0;
      r_assigned_slot <= 3'd0;
      r_entry_ack     <= 1'b0;
      r_entry_reject  <= 1'b0;
      r_exit_ack      <= 1'b0;
      r_exit_err      <= 1'b0;
      r_entry_gate    <= 1'b0;
      r_exit_gate     <= 1'b0;
    end else begin
      r_entry_ack    <= 1'b0;
      r_entry_reject <= 1'b0;
      r_exit_ack     <= 1'b0;
      r_exit_err     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // Exit has priority: it frees capacity.
          if (exit_req) begin
            r_served_exit <= 1'b1;
            if (w_exit_occ) begin
              r_free_mask  <= w_mask_set;
              r_free_count <= w_cnt_set;
              r_full       <= 1'b0;
              r_exit_ack   <= 1'b1;
              r_exit_gate  <= 1'b1;
              r_timer      <= TIMER_LOAD;
              r_state      <= S_EXIT_GATE;
            end else begin
              r_exit_err <= 1'b1;
              r_state    <= S_RELEASE;
            end
          end else if (entry_req) begin
            r_served_exit <= 1'b0;
            if (w_has_free) begin
              r_free_mask     <= w_mask_clr;
              r_free_count    <= w_cnt_clr;
              r_full          <= (w_mask_clr == 8'h00);
              r_assigned_slot <= w_low_idx;
              r_entry_ack     <= 1'b1;
              r_entry_gate    <= 1'b1;
              r_timer         <= TIMER_LOAD;
              r_state         <= S_ENTRY_GATE;
            end else begin
              r_entry_reject <= 1'b1;
              r_state        <= S_RELEASE;
            end
          end
        end
        S_ENTRY_GATE: begin
          if (r_timer == 4'd0) begin
            r_entry_gate <= 1'b0;
            r_state      <= S_RELEASE;
          end else begin
            r_timer <= r_timer - 4'd1;
          end
        end
        S_EXIT_GATE: begin
          if (r_timer == 4'd0) begin
            r_exit_gate <= 1'b0;
            r_state     <= S_RELEASE;
          end else begin
            r_timer <= r_timer - 4'd1;
          end
        end
        S_RELEASE: begin
          // Wait for the served sensor to clear so it is not granted twice.
          if (!w_served_req) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign entry_ack     = r_entry_ack;
  assign assigned_slot = r_assigned_slot;
  assign entry_reject  = r_entry_reject;
  assign exit_ack      = r_exit_ack;
  assign exit_err      = r_exit_err;
  assign entry_gate    = r_entry_gate;
  assign exit_gate     = r_exit_gate;
  assign free_mask     = r_free_mask;
  assign free_count    = r_free_count;
  assign full          = r_full;

endmodule

// File: tb/tb_parking_slot_controller.sv
// Directed bench for parking_slot_controller: slot allocation,
// gate timing, priority, error paths and held sensors.
module tb_parking_slot_controller;

  logic       clk;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic       entry_ack;
  logic [2:0] assigned_slot;
  logic       entry_reject;
  logic       exit_ack;
  logic       exit_err;
  logic       entry_gate;
  logic       exit_gate;
  logic [7:0] free_mask;
  logic [3:0] free_count;
  logic       full;

  int checks = 0;
  int errors = 0;

  parking_slot_controller #(.GATE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .exit_slot    (exit_slot),
    .entry_ack    (entry_ack),
    .assigned_slot(assigned_slot),
    .entry_reject (entry_reject),
    .exit_ack     (exit_ack),
    .exit_err     (exit_err),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .free_mask    (free_mask),
    .free_count   (free_count),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = 3'd0;
    do_reset();
    checks++;
    if (free_mask !== 8'hFF || free_count !== 4'd8 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state mask=%h cnt=%0d full=%b want FF 8 0",
               free_mask, free_count, full);
    end
    checks++;
    if (entry_gate !== 1'b0 || exit_gate !== 1'b0 || assigned_slot !== 3'd0) begin
      errors++;
      $display("FAIL reset_gates eg=%b xg=%b slot=%0d want 0 0 0",
               entry_gate, exit_gate, assigned_slot);
    end
    // Reset while the entry gate is open.
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++;
    if (entry_gate !== 1'b1 || free_mask !== 8'hFE) begin
      errors++;
      $display("FAIL reset_pre_gate eg=%b mask=%h want 1 FE", entry_gate, free_mask);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (entry_gate !== 1'b0 || free_mask !== 8'hFF || free_count !== 4'd8) begin
      errors++;
      $display("FAIL reset_mid_gate eg=%b mask=%h cnt=%0d want 0 FF 8",
               entry_gate, free_mask, free_count);
    end
    step();
  endtask

  task automatic test_fill_and_reject();
    int gate_cyc;
    int extra_acks;
    logic [7:0] exp_mask;
    exp_mask = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      entry_req = 1'b1;
      step();
      entry_req = 1'b0;
      exp_mask[s] = 1'b0;
      checks++;
      if (entry_ack !== 1'b1 || assigned_slot !== 3'(s) || free_mask !== exp_mask) begin
        errors++;
        $display("FAIL fill_grant%0d ack=%b slot=%0d mask=%h want 1 %0d %h",
                 s, entry_ack, assigned_slot, free_mask, s, exp_mask);
      end
      gate_cyc   = (entry_gate === 1'b1) ? 1 : 0;
      extra_acks = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (entry_gate === 1'b1) gate_cyc++;
        if (entry_ack === 1'b1) extra_acks++;
      end
      checks++;
      if (gate_cyc != 4 || extra_acks != 0) begin
        errors++;
        $display("FAIL fill_gate%0d high=%0d acks=%0d want 4 0",
                 s, gate_cyc, extra_acks);
      end
    end
    checks++;
    if (free_mask !== 8'h00 || full !== 1'b1 || free_count !== 4'd0) begin
      errors++;
      $display("FAIL fill_full mask=%h full=%b cnt=%0d want 00 1 0",
               free_mask, full, free_count);
    end
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++;
    if (entry_reject !== 1'b1 || entry_ack !== 1'b0 || entry_gate !== 1'b0
        || free_mask !== 8'h00) begin
      errors++;
      $display("FAIL ninth_reject rej=%b ack=%b eg=%b mask=%h want 1 0 0 00",
               entry_reject, entry_ack, entry_gate, free_mask);
    end
    step();
    checks++;
    if (entry_reject !== 1'b0 || entry_gate !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse rej=%b eg=%b want 0 0", entry_reject, entry_gate);
    end
    step();
    step();
  endtask

  task automatic test_lowest_reuse();
    exit_req  = 1'b1;
    exit_slot = 3'd5;
    step();
    exit_req = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || exit_gate !== 1'b1 || free_mask !== 8'h20
        || free_count !== 4'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL exit5 ack=%b xg=%b mask=%h cnt=%0d full=%b want 1 1 20 1 0",
               exit_ack, exit_gate, free_mask, free_count, full);
    end
    repeat (8) step();
    exit_req  = 1'b1;
    exit_slot = 3'd2;
    step();
    exit_req = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || free_mask !== 8'h24 || free_count !== 4'd2) begin
      errors++;
      $display("FAIL exit2 ack=%b mask=%h cnt=%0d want 1 24 2",
               exit_ack, free_mask, free_count);
    end
    repeat (8) step();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++;
    if (entry_ack !== 1'b1 || assigned_slot !== 3'd2 || free_mask !== 8'h20) begin
      errors++;
      $display("FAIL reuse_low ack=%b slot=%0d mask=%h want 1 2 20",
               entry_ack, assigned_slot, free_mask);
    end
    repeat (8) step();
  endtask

  task automatic test_simultaneous();
    int wait_cyc;
    bit got;
    do_reset();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    repeat (8) step();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    exit_slot = 3'd0;
    step();
    exit_req = 1'b0;
    checks++;
    if (exit_ack !== 1'b1 || entry_ack !== 1'b0 || free_mask !== 8'hFF) begin
      errors++;
      $display("FAIL simul_exit_first xack=%b eack=%b mask=%h want 1 0 FF",
               exit_ack, entry_ack, free_mask);
    end
    got      = 1'b0;
    wait_cyc = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      step();
      if (entry_ack === 1'b1) begin
        got      = 1'b1;
        wait_cyc = c;
      end
    end
    entry_req = 1'b0;
    checks++;
    if (!got || wait_cyc != 6) begin
      errors++;
      $display("FAIL simul_entry_after got=%b spacing=%0d want 1 6", got, wait_cyc);
    end
    checks++;
    if (assigned_slot !== 3'd0 || free_mask !== 8'hFE) begin
      errors++;
      $display("FAIL simul_entry_slot slot=%0d mask=%h want 0 FE",
               assigned_slot, free_mask);
    end
    repeat (8) step();
  endtask

  task automatic test_invalid_exit();
    do_reset();
    exit_req  = 1'b1;
    exit_slot = 3'd3;
    step();
    exit_req = 1'b0;
    checks++;
    if (exit_err !== 1'b1 || exit_ack !== 1'b0 || exit_gate !== 1'b0
        || free_mask !== 8'hFF) begin
      errors++;
      $display("FAIL invalid_exit err=%b ack=%b xg=%b mask=%h want 1 0 0 FF",
               exit_err, exit_ack, exit_gate, free_mask);
    end
    step();
    checks++;
    if (exit_err !== 1'b0 || exit_gate !== 1'b0) begin
      errors++;
      $display("FAIL invalid_exit_pulse err=%b xg=%b want 0 0", exit_err, exit_gate);
    end
    step();
    step();
  endtask

  task automatic test_held_sensor();
    int acks;
    do_reset();
    acks      = 0;
    entry_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (entry_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1 || free_mask !== 8'hFE || free_count !== 4'd7) begin
      errors++;
      $display("FAIL held_once acks=%0d mask=%h cnt=%0d want 1 FE 7",
               acks, free_mask, free_count);
    end
    entry_req = 1'b0;
    step();
    step();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++;
    if (entry_ack !== 1'b1 || assigned_slot !== 3'd1 || free_mask !== 8'hFC) begin
      errors++;
      $display("FAIL held_rearm ack=%b slot=%0d mask=%h want 1 1 FC",
               entry_ack, assigned_slot, free_mask);
    end
    repeat (8) step();
  endtask

  initial begin
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = 3'd0;
    test_reset();
    test_fill_and_reject();
    test_lowest_reuse();
    test_simultaneous();
    test_invalid_exit();
    test_held_sensor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
